// File: rtl/cla_pipe_if.sv
// cla_pipe_if: operand/result bus for the pipelined CLA adder/subtractor.
//
// Carries both handshakes of the block:
//   upstream   : in_valid, in_ready, a, b, cin, op
//   downstream : out_valid, out_ready, s, cout, ovf
// Modports:
//   master : producer of operands and consumer of results (testbench / host)
//   slave  : the cla_pipe datapath
interface cla_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/cla_pipe.sv
// cla_pipe: parametrised, pipelined carry look-ahead adder/subtractor.
//
// Operands are split into 4-bit CLA groups; GPS groups are evaluated per
// pipeline stage, with the carry between stages registered and the operand
// and partial-sum vectors skewed along the pipe. Latency from accept to
// out_valid is STAGES = WIDTH/(4*GPS) cycles; throughput is one beat/cycle.
//
// Ports:
//   wb_clk_i   clock, rising edge
//   wb_rst_i   synchronous active-high reset
//   vdd, vss   power pins (only when USE_POWER_PINS is defined)
//   bus        cla_pipe_if.slave: valid/ready operand input, valid/ready
//              result output (s, cout, ovf)
//
// Build options:
//   CLA_SATURATE_EN  clamp s to signed max/min on overflow
//   USE_POWER_PINS   expose vdd/vss
module cla_pipe #(
    parameter int WIDTH = 16,
    parameter int GPS   = 1
) (
    input  logic      wb_clk_i,
    input  logic      wb_rst_i,
`ifdef USE_POWER_PINS
    inout  wire       vdd,
    inout  wire       vss,
`endif
    cla_pipe_if.slave bus
);

    localparam int STAGES = WIDTH / (4 * GPS);
    localparam int LAST   = STAGES - 1;
    localparam int MSB    = WIDTH - 1;

    // Index 0 holds the captured beat (effective operands, carry-in); index
    // k+1 holds the beat after stage k has resolved its groups. Index STAGES
    // therefore drives the outputs.
    logic             v_q [STAGES+1];
    logic             c_q [STAGES+1];
    logic [WIDTH-1:0] a_q [STAGES+1];
    logic [WIDTH-1:0] b_q [STAGES+1];
    logic [WIDTH-1:0] s_q [STAGES+1];
    logic             ovf_q;

    logic             nx_c [STAGES];
    logic [WIDTH-1:0] nx_s [STAGES];
    logic             ovf_nx;
    logic             en;

    // One 4-bit look-ahead group: all four carries are derived directly from
    // the group carry-in, so the group delay does not ripple. Returns
    // {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] p,
                                        input logic [3:0] g,
                                        input logic       c0);
        logic c1, c2, c3, c4;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, p ^ {c3, c2, c1, c0}};
    endfunction

    // Global stall: the whole pipe moves only when the output slot is free
    // or being drained this cycle.
    assign en           = !v_q[STAGES] || bus.out_ready;
    assign bus.in_ready = en;

    assign bus.out_valid = v_q[STAGES];
    assign bus.s         = s_q[STAGES];
    assign bus.cout      = c_q[STAGES];
    assign bus.ovf       = ovf_q;

    // Each stage resolves its own GPS groups, chaining group carries inside
    // the stage, and merges its sum bits into the partial sum travelling
    // with the beat. The final stage also derives overflow.
    always_comb begin
        logic             carry;
        logic [WIDTH-1:0] sum;
        logic [4:0]       grp;
        int               base;
        carry = 1'b0;
        sum   = '0;
        grp   = '0;
        base  = 0;
        for (int k = 0; k < STAGES; k++) begin
            carry = c_q[k];
            sum   = s_q[k];
            for (int gi = 0; gi < GPS; gi++) begin
                base  = (k * GPS + gi) * 4;
                grp   = cla4(a_q[k][base +: 4] ^ b_q[k][base +: 4],
                             a_q[k][base +: 4] & b_q[k][base +: 4],
                             carry);
                carry = grp[4];
                sum[base +: 4] = grp[3:0];
            end
            nx_c[k] = carry;
            nx_s[k] = sum;
        end
        ovf_nx = (a_q[LAST][MSB] == b_q[LAST][MSB]) &&
                 (nx_s[LAST][MSB] != a_q[LAST][MSB]);
`ifdef CLA_SATURATE_EN
        // Clamp toward the sign of a: positive overflow -> 0111..1,
        // negative overflow -> 1000..0.
        if (ovf_nx) begin
            nx_s[LAST] = {a_q[LAST][MSB], {(WIDTH-1){~a_q[LAST][MSB]}}};
        end
`endif
    end

    // Pipeline registers. Subtraction is folded in at capture time
    // (b inverted, carry-in inverted), so later stages only ever add.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int k = 0; k <= STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (en) begin
            v_q[0] <= bus.in_valid;
            a_q[0] <= bus.a;
            b_q[0] <= bus.op ? ~bus.b : bus.b;
            c_q[0] <= bus.op ^ bus.cin;
            s_q[0] <= '0;
            for (int k = 0; k < STAGES; k++) begin
                v_q[k+1] <= v_q[k];
                c_q[k+1] <= nx_c[k];
                a_q[k+1] <= a_q[k];
                b_q[k+1] <= b_q[k];
                s_q[k+1] <= nx_s[k];
            end
            ovf_q <= ovf_nx;
        end
    end

endmodule

// File: tb/tb_cla_pipe.sv
// tb_cla_pipe: directed and randomised checks of cla_pipe.
// Main instance is WIDTH=16/GPS=1; three extra instances (4/1, 32/2, 32/8)
// are exercised by a streaming random test against an arithmetic model.
module tb_cla_pipe;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

`ifdef USE_POWER_PINS
    wire vdd;
    wire vss;
`endif

    cla_pipe_if #(.WIDTH(16)) bus16 ();
    cla_pipe_if #(.WIDTH(4))  bus4  ();
    cla_pipe_if #(.WIDTH(32)) bus32 ();
    cla_pipe_if #(.WIDTH(32)) bus32w ();

`ifdef USE_POWER_PINS
    cla_pipe #(.WIDTH(16), .GPS(1)) dut16 (.wb_clk_i(clk), .wb_rst_i(rst), .vdd(vdd), .vss(vss), .bus(bus16.slave));
    cla_pipe #(.WIDTH(4),  .GPS(1)) dut4  (.wb_clk_i(clk), .wb_rst_i(rst), .vdd(vdd), .vss(vss), .bus(bus4.slave));
    cla_pipe #(.WIDTH(32), .GPS(2)) dut32 (.wb_clk_i(clk), .wb_rst_i(rst), .vdd(vdd), .vss(vss), .bus(bus32.slave));
    cla_pipe #(.WIDTH(32), .GPS(8)) dut32w (.wb_clk_i(clk), .wb_rst_i(rst), .vdd(vdd), .vss(vss), .bus(bus32w.slave));
`else
    cla_pipe #(.WIDTH(16), .GPS(1)) dut16 (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus16.slave));
    cla_pipe #(.WIDTH(4),  .GPS(1)) dut4  (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus4.slave));
    cla_pipe #(.WIDTH(32), .GPS(2)) dut32 (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus32.slave));
    cla_pipe #(.WIDTH(32), .GPS(8)) dut32w (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus32w.slave));
`endif

    // Reference arithmetic: a +/- b +/- cin in w bits, returns {ovf, cout, s}.
    function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin,
                                          input logic op);
        logic [63:0] mask, aa, bb, full;
        logic [31:0] s;
        logic        co, sa, sb, sr, ov;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'd0, a} & mask;
        bb   = op ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
        full = aa + bb + {63'd0, op ^ cin};
        s    = full[31:0] & mask[31:0];
        co   = full[w];
        sa   = a[w-1];
        sb   = b[w-1];
        sr   = s[w-1];
        ov   = op ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
`ifdef CLA_SATURATE_EN
        if (ov) s = sa ? 32'(64'd1 << (w-1)) : 32'((64'd1 << (w-1)) - 64'd1);
`endif
        return {ov, co, s};
    endfunction

    // Drives one beat into the 16-bit instance and returns what emerges and
    // how many edges after the accept edge it took (20 = never appeared).
    task automatic send_beat(input logic [15:0] a, input logic [15:0] b,
                             input logic cin, input logic op,
                             output logic [15:0] rs, output logic rc,
                             output logic ro, output int lat);
        @(posedge clk); #1;
        bus16.out_ready = 1'b1;
        bus16.in_valid  = 1'b1;
        bus16.a   = a;
        bus16.b   = b;
        bus16.cin = cin;
        bus16.op  = op;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        lat = 0;
        while (!bus16.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = bus16.s;
        rc = bus16.cout;
        ro = bus16.ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compared += 5;
        if (bus16.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus16.out_valid); end
        if (bus16.s !== 16'h0000)     begin mismatched++; $display("[TB] FAIL reset_s: got %h expected 0000", bus16.s); end
        if (bus16.cout !== 1'b0)      begin mismatched++; $display("[TB] FAIL reset_cout: got %b expected 0", bus16.cout); end
        if (bus16.ovf !== 1'b0)       begin mismatched++; $display("[TB] FAIL reset_ovf: got %b expected 0", bus16.ovf); end
        if (bus16.in_ready !== 1'b1)  begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus16.in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic [15:0] va [3], vb [3], es [3];
        logic        vc [3], ec [3];
        logic [15:0] rs;
        logic        rc, ro;
        int          lat;
        va = '{16'hFFFF, 16'h1234, 16'hABCD};
        vb = '{16'h0001, 16'h0F0F, 16'h1357};
        vc = '{1'b0, 1'b1, 1'b0};
        es = '{16'h0000, 16'h2144, 16'hBF24};
        ec = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            send_beat(va[i], vb[i], vc[i], 1'b0, rs, rc, ro, lat);
            compared += 4;
            if (lat !== 4)    begin mismatched++; $display("[TB] FAIL add%0d_latency: got %0d expected 4", i, lat); end
            if (rs !== es[i]) begin mismatched++; $display("[TB] FAIL add%0d_s: got %h expected %h", i, rs, es[i]); end
            if (rc !== ec[i]) begin mismatched++; $display("[TB] FAIL add%0d_cout: got %b expected %b", i, rc, ec[i]); end
            if (ro !== 1'b0)  begin mismatched++; $display("[TB] FAIL add%0d_ovf: got %b expected 0", i, ro); end
        end
    endtask

    task automatic test_sub();
        logic [15:0] va [3], vb [3], es [3];
        logic        vc [3], ec [3];
        logic [15:0] rs;
        logic        rc, ro;
        int          lat;
        va = '{16'h0005, 16'h0010, 16'h0000};
        vb = '{16'h0007, 16'h0001, 16'h0000};
        vc = '{1'b0, 1'b1, 1'b0};
        es = '{16'hFFFE, 16'h000E, 16'h0000};
        ec = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            send_beat(va[i], vb[i], vc[i], 1'b1, rs, rc, ro, lat);
            compared += 3;
            if (rs !== es[i]) begin mismatched++; $display("[TB] FAIL sub%0d_s: got %h expected %h", i, rs, es[i]); end
            if (rc !== ec[i]) begin mismatched++; $display("[TB] FAIL sub%0d_cout: got %b expected %b", i, rc, ec[i]); end
            if (ro !== 1'b0)  begin mismatched++; $display("[TB] FAIL sub%0d_ovf: got %b expected 0", i, ro); end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] va [3], vb [3], es [3];
        logic        vo [3], ec [3];
        logic [15:0] rs;
        logic        rc, ro;
        int          lat;
        va = '{16'h8000, 16'h7FFF, 16'h8000};
        vb = '{16'h0001, 16'h0001, 16'h8000};
        vo = '{1'b1, 1'b0, 1'b0};
`ifdef CLA_SATURATE_EN
        es = '{16'h8000, 16'h7FFF, 16'h8000};
`else
        es = '{16'h7FFF, 16'h8000, 16'h0000};
`endif
        ec = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            send_beat(va[i], vb[i], 1'b0, vo[i], rs, rc, ro, lat);
            compared += 3;
            if (rs !== es[i]) begin mismatched++; $display("[TB] FAIL ovf%0d_s: got %h expected %h", i, rs, es[i]); end
            if (rc !== ec[i]) begin mismatched++; $display("[TB] FAIL ovf%0d_cout: got %b expected %b", i, rc, ec[i]); end
            if (ro !== 1'b1)  begin mismatched++; $display("[TB] FAIL ovf%0d_ovf: got %b expected 1", i, ro); end
        end
    endtask

    // 8 beats a = i*0x1111, b = 0x0101 while out_ready toggles every cycle.
    task automatic test_back_to_back();
        int          sent = 0;
        int          got  = 0;
        logic        prev_stalled = 1'b0;
        logic [15:0] prev_s = '0;
        logic [15:0] exp_s;
        bus16.in_valid = 1'b0;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            @(posedge clk); #1;
            if (prev_stalled) begin
                compared++;
                if (bus16.out_valid !== 1'b1 || bus16.s !== prev_s) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_hold: got valid=%b s=%h expected valid=1 s=%h", bus16.out_valid, bus16.s, prev_s);
                end
            end
            bus16.out_ready = (cyc % 2 == 0);
            bus16.in_valid  = (sent < 8);
            bus16.a   = 16'(sent * 16'h1111);
            bus16.b   = 16'h0101;
            bus16.cin = 1'b0;
            bus16.op  = 1'b0;
            #1;
            compared++;
            if (bus16.in_ready !== (!bus16.out_valid || bus16.out_ready)) begin
                mismatched++;
                $display("[TB] FAIL b2b_in_ready: got %b expected %b", bus16.in_ready, !bus16.out_valid || bus16.out_ready);
            end
            if (bus16.in_valid && bus16.in_ready) sent++;
            if (bus16.out_valid && bus16.out_ready) begin
                exp_s = 16'(got * 16'h1111 + 16'h0101);
                compared++;
                if (bus16.s !== exp_s) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_result%0d: got %h expected %h", got, bus16.s, exp_s);
                end
                got++;
            end
            prev_stalled = bus16.out_valid && !bus16.out_ready;
            prev_s       = bus16.s;
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        compared++;
        if (got !== 8) begin mismatched++; $display("[TB] FAIL b2b_count: got %0d expected 8", got); end
    endtask

    // Three beats in flight, one reset cycle: nothing may emerge afterwards.
    task automatic test_reset_in_flight();
        int          seen = 0;
        logic [15:0] rs;
        logic        rc, ro;
        int          lat;
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus16.in_valid = 1'b1;
            bus16.a   = 16'h1111 * 16'(i + 1);
            bus16.b   = 16'h2222;
            bus16.cin = 1'b1;
            bus16.op  = 1'b0;
        end
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        compared += 5;
        if (bus16.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rstfl_out_valid: got %b expected 0", bus16.out_valid); end
        if (bus16.s !== 16'h0000)     begin mismatched++; $display("[TB] FAIL rstfl_s: got %h expected 0000", bus16.s); end
        if (bus16.cout !== 1'b0)      begin mismatched++; $display("[TB] FAIL rstfl_cout: got %b expected 0", bus16.cout); end
        if (bus16.ovf !== 1'b0)       begin mismatched++; $display("[TB] FAIL rstfl_ovf: got %b expected 0", bus16.ovf); end
        if (bus16.in_ready !== 1'b1)  begin mismatched++; $display("[TB] FAIL rstfl_in_ready: got %b expected 1", bus16.in_ready); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus16.out_valid) seen++;
        end
        compared++;
        if (seen !== 0) begin mismatched++; $display("[TB] FAIL rstfl_ghost_beats: got %0d expected 0", seen); end
        send_beat(16'h0102, 16'h0304, 1'b0, 1'b0, rs, rc, ro, lat);
        compared++;
        if (rs !== 16'h0406 || lat !== 4) begin
            mismatched++;
            $display("[TB] FAIL rstfl_new_beat: got s=%h lat=%0d expected s=0406 lat=4", rs, lat);
        end
    endtask

    // Streaming random beats with bubbles into the 4/1, 32/2 and 32/8 builds.
    task automatic test_random();
        logic [33:0] q4 [$], q32 [$], q32w [$];
        logic [33:0] exp, obs;
        logic [31:0] ra, rb;
        logic        rc, ro;
        for (int cyc = 0; cyc < 420; cyc++) begin
            @(posedge clk); #1;
            if (bus4.out_valid) begin
                obs = {bus4.ovf, bus4.cout, 28'd0, bus4.s};
                exp = (q4.size() > 0) ? q4.pop_front() : 34'h3_FFFF_FFFF;
                compared++;
                if (obs !== exp) begin mismatched++; $display("[TB] FAIL rand_w4: got %h expected %h", obs, exp); end
            end
            if (bus32.out_valid) begin
                obs = {bus32.ovf, bus32.cout, bus32.s};
                exp = (q32.size() > 0) ? q32.pop_front() : 34'h3_FFFF_FFFF;
                compared++;
                if (obs !== exp) begin mismatched++; $display("[TB] FAIL rand_w32g2: got %h expected %h", obs, exp); end
            end
            if (bus32w.out_valid) begin
                obs = {bus32w.ovf, bus32w.cout, bus32w.s};
                exp = (q32w.size() > 0) ? q32w.pop_front() : 34'h3_FFFF_FFFF;
                compared++;
                if (obs !== exp) begin mismatched++; $display("[TB] FAIL rand_w32g8: got %h expected %h", obs, exp); end
            end
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); ro = 1'($urandom_range(0, 1));
            bus4.in_valid = (cyc < 400) && ($urandom_range(0, 3) != 0);
            bus4.a = ra[3:0]; bus4.b = rb[3:0]; bus4.cin = rc; bus4.op = ro;
            if (bus4.in_valid) q4.push_back(model(4, {28'd0, ra[3:0]}, {28'd0, rb[3:0]}, rc, ro));
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); ro = 1'($urandom_range(0, 1));
            bus32.in_valid = (cyc < 400) && ($urandom_range(0, 3) != 0);
            bus32.a = ra; bus32.b = rb; bus32.cin = rc; bus32.op = ro;
            if (bus32.in_valid) q32.push_back(model(32, ra, rb, rc, ro));
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); ro = 1'($urandom_range(0, 1));
            bus32w.in_valid = (cyc < 400) && ($urandom_range(0, 3) != 0);
            bus32w.a = ra; bus32w.b = rb; bus32w.cin = rc; bus32w.op = ro;
            if (bus32w.in_valid) q32w.push_back(model(32, ra, rb, rc, ro));
        end
        compared += 3;
        if (q4.size() != 0)   begin mismatched++; $display("[TB] FAIL rand_w4_drain: got %0d left expected 0", q4.size()); end
        if (q32.size() != 0)  begin mismatched++; $display("[TB] FAIL rand_w32g2_drain: got %0d left expected 0", q32.size()); end
        if (q32w.size() != 0) begin mismatched++; $display("[TB] FAIL rand_w32g8_drain: got %0d left expected 0", q32w.size()); end
    endtask

    initial begin
        rst = 1'b1;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.op = 1'b0;
        bus4.in_valid = 1'b0; bus4.out_ready = 1'b1; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.op = 1'b0;
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b1; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.op = 1'b0;
        bus32w.in_valid = 1'b0; bus32w.out_ready = 1'b1; bus32w.a = '0; bus32w.b = '0; bus32w.cin = 1'b0; bus32w.op = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_back_to_back();
        test_reset_in_flight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
